// File: rtl/pixel_pkg.sv
// Shared format codes and fill/stream state encoding for the pixel FIFO bridge.
package pixel_pkg;

  typedef enum logic [1:0] {
    FMT_GRAY8  = 2'd0,
    FMT_RGB332 = 2'd1,
    FMT_RGB565 = 2'd2,
    FMT_RGB888 = 2'd3
  } fmt_t;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/pixel_fifo_bridge_if.sv
// Pixel stream handshake bundle: source side (din) and display side (dout).
interface pixel_fifo_bridge_if #(
  parameter int IN_WIDTH = 24
) ();
  logic [IN_WIDTH-1:0] din;
  logic                din_valid;
  logic                din_ready;
  logic [23:0]         dout;
  logic                dout_valid;
  logic                dout_ready;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/pixel_fmt_expand.sv
// Combinational expansion of a packed source pixel to 24-bit RGB, channels MSB-replicated.
module pixel_fmt_expand
  import pixel_pkg::*;
#(
  parameter int IN_WIDTH = 24
) (
  input  logic [IN_WIDTH-1:0] din,
  input  fmt_t                fmt,
  output logic [23:0]         rgb
);

  logic [23:0] d;

  // Bits beyond IN_WIDTH read as zero.
  assign d = 24'(din);

  // NOTE: every path assigns rgb (default first), so no latch is inferred.
  always_comb begin
    rgb = d;
    case (fmt)
      FMT_GRAY8:  rgb = {d[7:0], d[7:0], d[7:0]};
      FMT_RGB332: rgb = {d[7:5], d[7:5], d[7:6],
                         d[4:2], d[4:2], d[4:3],
                         d[1:0], d[1:0], d[1:0], d[1:0]};
      FMT_RGB565: rgb = {d[15:11], d[15:13],
                         d[10:5],  d[10:9],
                         d[4:0],   d[4:2]};
      FMT_RGB888: rgb = d;
      default:    rgb = d;
    endcase
  end

endmodule

// File: rtl/pixel_fifo_bridge.sv
// Buffered pixel bridge: queue, prefill gating, RGB expansion into an output register.
// Optional statistics (underflow_count, level_max) built only with PIXEL_FIFO_STATS_EN.
module pixel_fifo_bridge
  import pixel_pkg::*;
#(
  parameter int IN_WIDTH = 24,
  parameter int LOGDEPTH = 10,
  parameter int PREFILL  = 512
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            fmt,
  pixel_fifo_bridge_if.slave    bus,
  output logic [LOGDEPTH:0]     level,
  output logic                  underflow,
  output logic [15:0]           underflow_count,
  output logic [LOGDEPTH:0]     level_max
);

  localparam int              DEPTH     = 1 << LOGDEPTH;
  localparam logic [LOGDEPTH:0] DEPTH_C   = (LOGDEPTH + 1)'(DEPTH);
  localparam logic [LOGDEPTH:0] PREFILL_C = (LOGDEPTH + 1)'(PREFILL);

  logic [IN_WIDTH-1:0] mem [DEPTH];
  logic [LOGDEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOGDEPTH:0]   count, count_next;
  state_t              state, state_next;
  logic                push, pop, prefill_met, out_free, underflow_evt;
  logic [23:0]         head_rgb;

  // Ready depends only on registered occupancy, so a pop at full cannot open it.
  assign bus.din_ready = (count != DEPTH_C) && !flush;
  assign push          = bus.din_valid && bus.din_ready;
  assign prefill_met   = (count >= PREFILL_C);
  assign out_free      = !bus.dout_valid || bus.dout_ready;
  assign level         = count;

  pixel_fmt_expand #(.IN_WIDTH(IN_WIDTH)) u_expand (
    .din (mem[rd_ptr]),
    .fmt (fmt_t'(fmt)),
    .rgb (head_rgb)
  );

  // FSM: state register
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (prefill_met)   state_next = STREAM;
      STREAM:  if (underflow_evt) state_next = FILL;
      default: state_next = FILL;
    endcase
    if (flush) state_next = FILL;
  end

  // FSM: outputs that steer the datapath
  always_comb begin
    pop           = !flush && (count != '0) && out_free &&
                    ((state == STREAM) || prefill_met);
    underflow_evt = !flush && (state == STREAM) && bus.dout_ready &&
                    !bus.dout_valid && (count == '0);
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
    if (flush) count_next = '0;
  end

  // NOTE: the storage array is deliberately not reset; only pointers and count are.
  always_ff @(posedge pixel_clk) begin
    if (push) mem[wr_ptr] <= bus.din;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      underflow      <= 1'b0;
    end else if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr         <= rd_ptr + 1'b1;
        bus.dout       <= head_rgb;
        bus.dout_valid <= 1'b1;
      end else if (bus.dout_ready) begin
        bus.dout_valid <= 1'b0;
      end
      if (underflow_evt) underflow <= 1'b1;
    end
  end

`ifdef PIXEL_FIFO_STATS_EN
  // Statistics survive flush; only rst clears them.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      underflow_count <= '0;
      level_max       <= '0;
    end else begin
      if (underflow_evt && (underflow_count != 16'hFFFF))
        underflow_count <= underflow_count + 1'b1;
      if (count_next > level_max)
        level_max <= count_next;
    end
  end
`else
  assign underflow_count = '0;
  assign level_max       = '0;
`endif

endmodule

// File: tb/tb_pixel_fifo_bridge.sv
// Directed bench for pixel_fifo_bridge with DEPTH=4, PREFILL=4.
module tb_pixel_fifo_bridge;
  import pixel_pkg::*;

  localparam int IN_WIDTH = 24;
  localparam int LOGDEPTH = 2;
  localparam int PREFILL  = 4;

  logic                pixel_clk = 1'b0;
  logic                rst;
  logic                flush;
  logic [1:0]          fmt;
  logic [LOGDEPTH:0]   level;
  logic                underflow;
  logic [15:0]         underflow_count;
  logic [LOGDEPTH:0]   level_max;

  int n_checks = 0;
  int n_pass   = 0;

  pixel_fifo_bridge_if #(.IN_WIDTH(IN_WIDTH)) bus ();

  pixel_fifo_bridge #(
    .IN_WIDTH (IN_WIDTH),
    .LOGDEPTH (LOGDEPTH),
    .PREFILL  (PREFILL)
  ) dut (
    .pixel_clk       (pixel_clk),
    .rst             (rst),
    .flush           (flush),
    .fmt             (fmt),
    .bus             (bus.slave),
    .level           (level),
    .underflow       (underflow),
    .underflow_count (underflow_count),
    .level_max       (level_max)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  // Present one pixel and hold it until accepted, within a bounded wait.
  task automatic push(input logic [23:0] d);
    int waited;
    waited        = 0;
    bus.din       = d;
    bus.din_valid = 1'b1;
    while (!bus.din_ready && waited < 16) begin
      tick();
      waited++;
    end
    if (!bus.din_ready) check("push_wait_din_ready", 32'(bus.din_ready), 32'd1);
    else tick();
    bus.din_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    fmt            = FMT_GRAY8;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    tick();
    tick();
    check("rst_level",      32'(level),          32'd0);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_dout",       32'(bus.dout),       32'd0);
    check("rst_underflow",  32'(underflow),      32'd0);
    check("rst_din_ready",  32'(bus.din_ready),  32'd1);
    rst = 1'b0;
    tick();

    // Prefill: nothing leaves until four pixels are queued
    bus.dout_ready = 1'b1;
    push(24'h11);
    check("pf_level1", 32'(level), 32'd1);
    check("pf_dv1", 32'(bus.dout_valid), 32'd0);
    push(24'h22);
    push(24'h33);
    check("pf_dv3", 32'(bus.dout_valid), 32'd0);
    push(24'h44);
    check("pf_level4", 32'(level), 32'd4);
    check("pf_dv4", 32'(bus.dout_valid), 32'd0);
    tick();
    check("pf_dv_out", 32'(bus.dout_valid), 32'd1);
    check("pf_out0", 32'(bus.dout), 32'h111111);
    tick();
    check("pf_out1", 32'(bus.dout), 32'h222222);
    tick();
    check("pf_out2", 32'(bus.dout), 32'h333333);
    tick();
    check("pf_out3", 32'(bus.dout), 32'h444444);
    check("pf_level0", 32'(level), 32'd0);

    // Starve the stream: drain, then the underflow edge
    tick();
    check("uf_dv_drained", 32'(bus.dout_valid), 32'd0);
    check("uf_not_yet", 32'(underflow), 32'd0);
    tick();
    check("uf_sticky", 32'(underflow), 32'd1);
`ifdef PIXEL_FIFO_STATS_EN
    check("uf_count", 32'(underflow_count), 32'd1);
`else
    check("uf_count", 32'(underflow_count), 32'd0);
`endif

    // Back in FILL: formats, output withheld until refilled
    push(24'h00F800);
    check("refill_dv1", 32'(bus.dout_valid), 32'd0);
    push(24'h0007E0);
    push(24'h000003);
    check("refill_dv3", 32'(bus.dout_valid), 32'd0);
    push(24'h123456);
    check("refill_dv4", 32'(bus.dout_valid), 32'd0);
    fmt = FMT_RGB565;
    tick();
    check("fmt565_red", 32'(bus.dout), 32'hFF0000);
    tick();
    check("fmt565_green", 32'(bus.dout), 32'h00FF00);
    fmt = FMT_RGB332;
    tick();
    check("fmt332_blue", 32'(bus.dout), 32'h0000FF);
    fmt = FMT_RGB888;
    tick();
    check("fmt888_pass", 32'(bus.dout), 32'h123456);
    bus.dout_ready = 1'b0;

    // Flush with three queued and the output register full
    push(24'h000001);
    push(24'h000002);
    push(24'h000003);
    check("fl_level3", 32'(level), 32'd3);
    check("fl_dv_held", 32'(bus.dout_valid), 32'd1);
    flush = 1'b1;
    #1;
    check("fl_ready_gated", 32'(bus.din_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_level", 32'(level), 32'd0);
    check("fl_dv", 32'(bus.dout_valid), 32'd0);
    check("fl_underflow", 32'(underflow), 32'd0);
    check("fl_din_ready", 32'(bus.din_ready), 32'd1);

    // Full: four queued plus one in the output register
    fmt = FMT_GRAY8;
    for (int i = 1; i <= 5; i++) push(24'(i));
    check("full_din_ready", 32'(bus.din_ready), 32'd0);
    check("full_level", 32'(level), 32'd4);
    check("full_dv", 32'(bus.dout_valid), 32'd1);
    check("full_dout", 32'(bus.dout), 32'h010101);
    bus.din       = 24'h06;
    bus.din_valid = 1'b1;
    tick();
    check("full_blocked_level", 32'(level), 32'd4);
    bus.dout_ready = 1'b1;
    #1;
    check("full_pop_no_ready", 32'(bus.din_ready), 32'd0);
    tick();
    check("full_pop_level", 32'(level), 32'd3);
    check("full_pop_dout", 32'(bus.dout), 32'h020202);
    tick();
    check("pushpop_level", 32'(level), 32'd3);
    check("pushpop_dout", 32'(bus.dout), 32'h030303);
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    tick();
`ifdef PIXEL_FIFO_STATS_EN
    check("stats_level_max", 32'(level_max), 32'd4);
`else
    check("stats_level_max", 32'(level_max), 32'd0);
`endif

    // Asynchronous reset mid-stream: outputs clear without waiting for an edge
    rst = 1'b1;
    #1;
    check("arst_dv", 32'(bus.dout_valid), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_uf_count", 32'(underflow_count), 32'd0);
    check("arst_level_max", 32'(level_max), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("arst_din_ready", 32'(bus.din_ready), 32'd1);
    check("arst_dout", 32'(bus.dout), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
